// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO read port into an in-order valid/ready stream.
// Latency: rdreq in cycle N gives valid_o in cycle N+RD_LATENCY+1 when the skid buffer is empty.
// Backpressure: rdreq is credit-limited by buffer occupancy plus reads in flight, never by ready_i.
//
// Ports:
//   clk_i, arst_n_i                    clock, asynchronous active-low reset
//   fifo_rdreq_o, fifo_q_i, fifo_empty_i   FIFO read port (RD_LATENCY 0/1/2)
//   data_o, valid_o, ready_i           downstream stream, data_o/valid_o straight from flops
//   xfer_cnt_o                         accepted-beat counter, only with FIFO_RD_STREAM_CNT_EN defined
module fifo_rd_stream #(
  parameter int DWIDTH     = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  output logic              fifo_rdreq_o,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]       xfer_cnt_o
`endif
);

  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PW    = $clog2(DEPTH + 1);
  // Storage is sized to the full pointer range so indexing needs no width fixups;
  // only the first DEPTH slots are ever addressed.
  localparam int NSLOT = 1 << PW;
  localparam int IW    = (RD_LATENCY > 0) ? RD_LATENCY : 1;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
  localparam logic [PW:0]   DEPTH_W = (PW + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem_q [NSLOT];
  logic [DWIDTH-1:0] mem_d [NSLOT];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     occ_q, occ_d;
  logic [PW-1:0]     pending;
  logic [IW-1:0]     inflight_q;
  logic              capture;
  logic              pop;
  logic [DWIDTH-1:0] data_q;
  logic              valid_q;

  // In-flight tracking: bit i set means a read issued i+1 cycles ago.
  if (RD_LATENCY == 0) begin : g_showahead
    assign inflight_q = '0;
    assign capture    = fifo_rdreq_o;
  end else begin : g_latency
    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        inflight_q <= '0;
      end else begin
        inflight_q <= (inflight_q << 1) | IW'(fifo_rdreq_o);
      end
    end
    assign capture = inflight_q[IW-1];
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < IW; i++) begin
      pending = pending + PW'(inflight_q[i]);
    end
  end

  // Credit rule: never request more than the buffer can absorb once every
  // outstanding read has landed. Held low in reset so no read escapes then.
  assign fifo_rdreq_o = arst_n_i && !fifo_empty_i &&
                        (({1'b0, occ_q} + {1'b0, pending}) < DEPTH_W);

  assign pop = valid_q && ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (capture) begin
      mem_d[wr_ptr_q] = fifo_q_i;
      wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({capture, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage needs no reset: nothing is read from it until occupancy says so.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      // Output flops are loaded from next state so the stream head is registered.
      valid_q  <= (occ_d != '0);
      data_q   <= mem_d[rd_ptr_d];
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] xfer_cnt_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      xfer_cnt_q <= '0;
    end else if (pop) begin
      xfer_cnt_q <= xfer_cnt_q + 32'd1;
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
`endif

`ifndef SYNTHESIS
  // The credit rule makes this unreachable; a hit means the credit logic is broken.
  overflow_chk: assert property (@(posedge clk_i) disable iff (!arst_n_i)
                                 !(capture && (occ_q == DEPTH_P)))
    else $error("fifo_rd_stream: capture into a full skid buffer");
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int DW = 64;
  localparam int NL = 3;   // lane l runs the DUT with RD_LATENCY = l
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Behavioural FIFO per lane
  logic [DW-1:0] fmem [NL][1<<AW];
  logic [AW-1:0] head [NL];
  logic [AW-1:0] tail [NL];
  logic [DW-1:0] q1 [NL];
  logic [DW-1:0] q2 [NL];
  logic [DW-1:0] fq [NL];
  logic          fempty [NL];
  logic          rdreq [NL];
  logic          valid [NL];
  logic          ready [NL];
  logic [DW-1:0] dat [NL];
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0]   cnt [NL];
`endif
  int            empty_rd [NL];

  int checks = 0;
  int errors = 0;

  always @(posedge clk or negedge rst_n) begin
    for (int l = 0; l < NL; l++) begin
      if (!rst_n) begin
        head[l] <= '0;
      end else begin
        if (rdreq[l]) begin
          head[l] <= head[l] + 1'b1;
          q1[l]   <= fmem[l][head[l]];
        end
        q2[l] <= q1[l];
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (rst_n && rdreq[l] && fempty[l]) empty_rd[l] <= empty_rd[l] + 1;
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign fempty[g] = (head[g] == tail[g]);
    if (g == 0) begin : g_q0
      assign fq[g] = fmem[g][head[g]];
    end else if (g == 1) begin : g_q1
      assign fq[g] = q1[g];
    end else begin : g_q2
      assign fq[g] = q2[g];
    end
    fifo_rd_stream #(.DWIDTH(DW), .RD_LATENCY(g)) u_dut (
      .clk_i        (clk),
      .arst_n_i     (rst_n),
      .fifo_rdreq_o (rdreq[g]),
      .fifo_q_i     (fq[g]),
      .fifo_empty_i (fempty[g]),
      .data_o       (dat[g]),
      .valid_o      (valid[g]),
      .ready_i      (ready[g])
`ifdef FIFO_RD_STREAM_CNT_EN
      ,
      .xfer_cnt_o   (cnt[g])
`endif
    );
  end

  task automatic push(input int l, input logic [DW-1:0] w);
    fmem[l][tail[l]] = w;
    tail[l] = tail[l] + 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int l = 0; l < NL; l++) begin
      ready[l] = 1'b0;
      tail[l]  = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (valid[l] !== 1'b0 || rdreq[l] !== 1'b0 || dat[l] !== '0) begin
        errors++;
        $display("FAIL reset_state lane%0d: valid=%b rdreq=%b data=%h, want 0/0/0", l, valid[l], rdreq[l], dat[l]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (rdreq[l] !== 1'b0 || valid[l] !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset lane%0d: rdreq=%b valid=%b, want 0/0", l, rdreq[l], valid[l]);
      end
    end
  endtask

  task automatic test_fill_drain;
    int first_rd = -1;
    int first_vld = -1;
    int beats = 0;
    int e0 = empty_rd[1];
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push(1, DW'(i));
    ready[1] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rdreq[1] && first_rd < 0) first_rd = c;
      if (valid[1]) begin
        if (first_vld < 0) first_vld = c;
        checks++;
        if (dat[1] !== DW'(beats + 1) || c != beats + 2) begin
          errors++;
          $display("FAIL fill_beat: cycle %0d data %h, want cycle %0d data %0d", c, dat[1], beats + 2, beats + 1);
        end
        beats++;
      end
    end
    ready[1] = 1'b0;
    checks++;
    if (first_rd != 0) begin errors++; $display("FAIL fill_first_rdreq: cycle %0d, want 0", first_rd); end
    checks++;
    if (first_vld != 2) begin errors++; $display("FAIL fill_first_valid: cycle %0d, want 2", first_vld); end
    checks++;
    if (beats != 8) begin errors++; $display("FAIL fill_beat_count: %0d, want 8", beats); end
    checks++;
    if (empty_rd[1] != e0) begin errors++; $display("FAIL fill_rdreq_when_empty: %0d, want 0", empty_rd[1] - e0); end
  endtask

  task automatic test_showahead;
    @(negedge clk);
    push(0, 64'hA5);
    #1;
    checks++;
    if (rdreq[0] !== 1'b1 || valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL showahead_cycle_n: rdreq=%b valid=%b, want 1/0", rdreq[0], valid[0]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (valid[0] !== 1'b1 || dat[0] !== 64'hA5 || rdreq[0] !== 1'b0) begin
      errors++;
      $display("FAIL showahead_cycle_n1: valid=%b data=%h rdreq=%b, want 1/a5/0", valid[0], dat[0], rdreq[0]);
    end
    ready[0] = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (valid[0] !== 1'b0 || rdreq[0] !== 1'b0) begin
      errors++;
      $display("FAIL showahead_after_pop: valid=%b rdreq=%b, want 0/0", valid[0], rdreq[0]);
    end
    ready[0] = 1'b0;
  endtask

  task automatic test_backpressure;
    int pulses = 0;
    int unstable = 0;
    int k = 0;
    int gaps = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) push(2, 64'hB000 + DW'(i));
    ready[2] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rdreq[2]) pulses++;
      if (valid[2] && dat[2] !== 64'hB000) unstable++;
    end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL bp_rdreq_pulses: %0d, want 4", pulses); end
    checks++;
    if (valid[2] !== 1'b1 || dat[2] !== 64'hB000 || unstable != 0) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=%h unstable=%0d, want 1/b000/0", valid[2], dat[2], unstable);
    end
    @(negedge clk);
    ready[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0 || c == 1) begin
        checks++;
        if (rdreq[2] !== (c == 1)) begin
          errors++;
          $display("FAIL bp_resume c%0d: rdreq=%b, want %0d", c, rdreq[2], c == 1);
        end
      end
      if (valid[2]) begin
        checks++;
        if (dat[2] !== 64'hB000 + DW'(k)) begin
          errors++;
          $display("FAIL bp_order beat%0d: data %h, want %h", k, dat[2], 64'hB000 + DW'(k));
        end
        k++;
      end else if (k > 0 && k < 10) begin
        gaps++;
      end
    end
    ready[2] = 1'b0;
    checks++;
    if (k != 10 || gaps != 0) begin
      errors++;
      $display("FAIL bp_drain: beats=%0d gaps=%0d, want 10/0", k, gaps);
    end
  endtask

  task automatic test_reset_midrun;
    int k = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) push(2, 64'hC000 + DW'(i));
    ready[2] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (valid[2] !== 1'b1 || rdreq[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup: valid=%b rdreq=%b, want 1/1", valid[2], rdreq[2]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid[2] !== 1'b0 || rdreq[2] !== 1'b0 || dat[2] !== '0) begin
      errors++;
      $display("FAIL midrun_async_reset: valid=%b rdreq=%b data=%h, want 0/0/0", valid[2], rdreq[2], dat[2]);
    end
    for (int l = 0; l < NL; l++) tail[l] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(2, 64'h77);
    push(2, 64'h88);
    ready[2] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (valid[2]) begin
        checks++;
        if (dat[2] !== ((k == 0) ? 64'h77 : 64'h88) || k > 1) begin
          errors++;
          $display("FAIL midrun_after_reset beat%0d: data %h, want %h", k, dat[2], (k == 0) ? 64'h77 : 64'h88);
        end
        k++;
      end
    end
    ready[2] = 1'b0;
    checks++;
    if (k != 2) begin errors++; $display("FAIL midrun_beat_count: %0d, want 2", k); end
  endtask

  task automatic test_random_ready;
    for (int l = 0; l < NL; l++) begin
      logic [AW-1:0] start;
      logic [DW-1:0] w;
      int n_push = 0;
      int k = 0;
      start = tail[l];
      for (int cyc = 0; cyc < 8000 && k < 1000; cyc++) begin
        @(negedge clk);
        if (n_push < 1000 && $urandom_range(0, 3) != 0) begin
          w = {$urandom, $urandom};
          push(l, w);
          n_push++;
        end
        ready[l] = ($urandom_range(0, 1) == 1);
        #1;
        if (valid[l] && ready[l]) begin
          checks++;
          if (dat[l] !== fmem[l][AW'(start + AW'(k))]) begin
            errors++;
            $display("FAIL random lane%0d beat%0d: data %h, want %h", l, k, dat[l], fmem[l][AW'(start + AW'(k))]);
          end
          k++;
        end
      end
      ready[l] = 1'b0;
      checks++;
      if (k != 1000) begin errors++; $display("FAIL random_count lane%0d: %0d beats, want 1000", l, k); end
    end
  endtask

`ifdef FIFO_RD_STREAM_CNT_EN
  task automatic test_counter;
    int k = 0;
    rst_n = 1'b0;
    for (int l = 0; l < NL; l++) tail[l] = '0;
    #1;
    checks++;
    if (cnt[1] !== 32'd0) begin errors++; $display("FAIL cnt_reset: %0d, want 0", cnt[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 300; i++) push(1, DW'(i));
    ready[1] = 1'b1;
    for (int c = 0; c < 1000 && k < 300; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (valid[1]) k++;
    end
    ready[1] = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (cnt[1] !== 32'd300) begin errors++; $display("FAIL cnt_300: %0d, want 300", cnt[1]); end
    force g_lane[1].u_dut.xfer_cnt_q = 32'hFFFF_FFFF;
    #1;
    release g_lane[1].u_dut.xfer_cnt_q;
    push(1, 64'h1234);
    ready[1] = 1'b1;
    k = 0;
    for (int c = 0; c < 10 && k == 0; c++) begin
      @(negedge clk);
      #1;
      if (valid[1]) k++;
    end
    ready[1] = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (k != 1 || cnt[1] !== 32'd0) begin
      errors++;
      $display("FAIL cnt_wrap: beats=%0d cnt=%h, want 1/00000000", k, cnt[1]);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int l = 0; l < NL; l++) begin
      ready[l] = 1'b0;
      tail[l]  = '0;
    end
    test_reset();
    test_fill_drain();
    test_showahead();
    test_backpressure();
    test_reset_midrun();
    test_random_ready();
`ifdef FIFO_RD_STREAM_CNT_EN
    test_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter that drains the team's synchronous FIFO and presents its contents as a valid/ready stream. It issues `rdreq` to the FIFO, absorbs the FIFO's fixed read latency (showahead, normal, or registered-output mode) in a small credit-controlled skid buffer, and delivers words in order with no loss or duplication. It sits between the FIFO's read port and any downstream consumer that can apply backpressure.

## Interface
Parameters:
- `DWIDTH`, 64: data width in bits; must match the FIFO `DWIDTH`.
- `RD_LATENCY`, 1: cycles from `fifo_rdreq_o` to valid `fifo_q_i`. Legal values:
  - 0: showahead.
  - 1: normal.
  - 2: normal plus registered output.

Ports:
- `clk_i`, in, 1: clock. Everything is on the rising edge.
- `arst_n_i`, in, 1: reset, asynchronous, active-low.
- `fifo_rdreq_o`, out, 1: read request to the FIFO.
- `fifo_q_i`, in, DWIDTH: FIFO read data.
- `fifo_empty_i`, in, 1: FIFO empty flag.
- `data_o`, out, DWIDTH: stream data.
- `valid_o`, out, 1: stream data valid.
- `ready_i`, in, 1: downstream ready.
- `xfer_cnt_o`, out, 32: accepted-beat counter. Present only with `FIFO_RD_STREAM_CNT_EN`.

## Operation
- **Skid buffer.** Circular buffer of `DEPTH = RD_LATENCY + 2` entries.
  - Write pointer, read pointer and occupancy counter are each `$clog2(DEPTH+1)` bits wide.
  - Pointers wrap modulo DEPTH, not modulo a power of two.
- **In-flight tracking.** A shift register `inflight[RD_LATENCY-1:0]` records the reads that have been issued but not yet returned.
  - `pending = popcount(inflight)`.
  - For RD_LATENCY=0 the register does not exist and pending = 0.
- **Read request.**
  - `fifo_rdreq_o = !fifo_empty_i && (occupancy + pending) < DEPTH`.
  - This is combinational from registered state plus `fifo_empty_i`.
  - It never depends on `ready_i`. This keeps the path free of combinational paths from the downstream consumer.
- **Capture.** `fifo_q_i` is written into the buffer on the edge that ends the cycle in which the request was issued, delayed by RD_LATENCY cycles.
  - RD_LATENCY=0: capture in the same cycle as `fifo_rdreq_o`.
  - RD_LATENCY≥1: capture when `inflight[RD_LATENCY-1]` = 1.
- **Output.**
  - `valid_o = (occupancy != 0)`.
  - `data_o` = buffer entry at the read pointer.
  - Both are driven from registers only.
- **Handshake.**
  - A beat transfers on an edge where `valid_o && ready_i`. The read pointer advances and occupancy decrements.
  - `data_o` and `valid_o` hold stable while `valid_o && !ready_i`.
- **Simultaneous capture and pop.** Occupancy is unchanged and both pointers advance.
- **Overflow.** The credit rule makes buffer overflow impossible. If a capture ever arrives with occupancy == DEPTH, that is a design error and must be flagged by a simulation assertion.
- **Empty FIFO.** Never issue `rdreq` while `fifo_empty_i`=1. The FIFO's empty flag updates one cycle after the pop.
- **Reset.**
  - On `arst_n_i` low, immediately clear: pointers, occupancy, `inflight`, and `xfer_cnt_o`.
  - Reset values: `valid_o`=0, `fifo_rdreq_o`=0, `data_o`=0.
  - Words returning from reads issued before reset are discarded. The FIFO must be reset together with this block.
  - Deassertion is synchronized externally. The first `rdreq` can occur in the first cycle after release.

## Timing
- **Latency.** A request in cycle N produces `valid_o`=1 in cycle N+RD_LATENCY+1, provided the buffer was empty.
- **Throughput.** One word per cycle when `ready_i` is held at 1 and the FIFO is non-empty. DEPTH covers the full request→capture→pop loop.
- **Backpressure.**
  - With `ready_i`=0, at most DEPTH words are requested; `fifo_rdreq_o` then drops.
  - After `ready_i` rises, `rdreq` resumes in the cycle following the first pop.
- **Registers.** All outputs except `fifo_rdreq_o` come directly from flops.

## Configuration
- **With `FIFO_RD_STREAM_CNT_EN` defined:**
  - Adds port `xfer_cnt_o`, a 32-bit counter that increments on every `valid_o && ready_i` edge.
  - It wraps from 0xFFFF_FFFF to 0 and resets to 0.
- **Without it:** the port and the counter do not exist. Data-path behaviour is identical in both builds.

## Test plan
- **Fill-and-drain.** RD_LATENCY=1; FIFO preloaded with 0x1..0x8; `ready_i`=1 throughout.
  - Required: `rdreq` first seen in cycle 0; `valid_o` first high in cycle 2.
  - Required: 8 consecutive beats 0x1..0x8; `rdreq` never asserted while empty.
- **Backpressure.** RD_LATENCY=2; 10 words; `ready_i`=0.
  - Required: exactly 4 `rdreq` pulses, `valid_o`=1, `data_o`=word0 held stable.
  - Release `ready_i` → all 10 words delivered in order, no gaps after the first pop.
- **Showahead.** RD_LATENCY=0; one word 0xA5.
  - Required: rdreq and capture in cycle N; `valid_o` in N+1; no second read.
- **Random ready.** 1000 random words; `ready_i` random with 50% duty; each legal RD_LATENCY.
  - Required: output sequence equals input sequence and the overflow assertion never fires.
- **Reset mid-run.** Assert `arst_n_i` while 2 reads are in flight.
  - Required: `valid_o`/`fifo_rdreq_o` go to 0 without waiting for a clock edge.
  - Required: in-flight data is dropped; after reset, new words arrive correctly.
- **Counter.** With `FIFO_RD_STREAM_CNT_EN` defined, transfer 300 beats.
  - Required: `xfer_cnt_o`=300.
  - Force the counter to 0xFFFF_FFFF and transfer 1 beat → 0.
